// File: rtl/i2c_tgt_pkg.sv
// Shared types and constants for the I2C register target.
package i2c_tgt_pkg;

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        PTR,
        PTR_ACK,
        WDATA,
        WACK,
        RDATA,
        RACK,
        WAIT_STOP
    } state_e;

    localparam logic        I2C_ACK   = 1'b0;
    localparam logic        I2C_NACK  = 1'b1;
    localparam int unsigned BYTE_BITS = 8;
    localparam int unsigned CNT_W     = 4;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/i2c_tgt_if.sv
// I2C bus as seen by the target: sampled line levels in, SDA pull-down enable out.
interface i2c_tgt_if;
    logic scl_i;
    logic sda_i;
    logic sda_oe;

    modport master (output scl_i, output sda_i, input sda_oe);
    modport slave  (input scl_i, input sda_i, output sda_oe);
endinterface

// File: rtl/i2c_tgt_cond_det.sv
// SCL/SDA synchronizers and bus-condition detection (START/STOP/SCL edges).
// Optional 3-sample majority filter when I2C_TGT_GLITCH_FILTER_EN is defined.
module i2c_tgt_cond_det (
    input  logic clk,
    input  logic rst_n,
    input  logic scl_i,
    input  logic sda_i,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det,
    output logic sda_s
);
    logic [1:0] scl_sync_q, sda_sync_q;
    logic       scl_cur, sda_cur;
    logic       scl_prev_q, sda_prev_q;
    logic       scl_rise_q, scl_fall_q, start_q, stop_q, sda_s_q;
    logic       scl_rise_d, scl_fall_d, start_d, stop_d;

`ifdef I2C_TGT_GLITCH_FILTER_EN
    logic [1:0] scl_hist_q, sda_hist_q;
    logic       scl_flt_q, sda_flt_q, scl_flt_d, sda_flt_d;

    always_comb begin
        scl_flt_d = i2c_tgt_pkg::maj3(scl_sync_q[1], scl_hist_q[0], scl_hist_q[1]);
        sda_flt_d = i2c_tgt_pkg::maj3(sda_sync_q[1], sda_hist_q[0], sda_hist_q[1]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_hist_q <= 2'b11;
            sda_hist_q <= 2'b11;
            scl_flt_q  <= 1'b1;
            sda_flt_q  <= 1'b1;
        end else begin
            scl_hist_q <= {scl_hist_q[0], scl_sync_q[1]};
            sda_hist_q <= {sda_hist_q[0], sda_sync_q[1]};
            scl_flt_q  <= scl_flt_d;
            sda_flt_q  <= sda_flt_d;
        end
    end

    assign scl_cur = scl_flt_q;
    assign sda_cur = sda_flt_q;
`else
    assign scl_cur = scl_sync_q[1];
    assign sda_cur = sda_sync_q[1];
`endif

    // START/STOP need SCL high in both the previous and current sample
    always_comb begin
        scl_rise_d = scl_cur & ~scl_prev_q;
        scl_fall_d = ~scl_cur & scl_prev_q;
        start_d    = scl_cur & scl_prev_q & sda_prev_q & ~sda_cur;
        stop_d     = scl_cur & scl_prev_q & ~sda_prev_q & sda_cur;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync_q <= 2'b11;
            sda_sync_q <= 2'b11;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
            scl_rise_q <= 1'b0;
            scl_fall_q <= 1'b0;
            start_q    <= 1'b0;
            stop_q     <= 1'b0;
            sda_s_q    <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[0], scl_i};
            sda_sync_q <= {sda_sync_q[0], sda_i};
            scl_prev_q <= scl_cur;
            sda_prev_q <= sda_cur;
            scl_rise_q <= scl_rise_d;
            scl_fall_q <= scl_fall_d;
            start_q    <= start_d;
            stop_q     <= stop_d;
            sda_s_q    <= sda_cur;
        end
    end

    assign scl_rise  = scl_rise_q;
    assign scl_fall  = scl_fall_q;
    assign start_det = start_q;
    assign stop_det  = stop_q;
    assign sda_s     = sda_s_q;
endmodule

// File: rtl/i2c_target_regs.sv
// I2C target with a small 8-bit register file, write reporting and a local read port.
// Build option I2C_TGT_GLITCH_FILTER_EN enables the input majority filter.
module i2c_target_regs
    import i2c_tgt_pkg::*;
#(
    parameter logic [6:0]   DEV_ADDR = 7'h50,
    parameter int unsigned  NUM_REGS = 16,
    localparam int unsigned REG_AW   = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              reset,
    i2c_tgt_if.slave          bus,
    output logic              busy,
    output logic              wr_valid,
    output logic [REG_AW-1:0] wr_addr,
    output logic [7:0]        wr_data,
    input  logic [REG_AW-1:0] loc_addr,
    output logic [7:0]        loc_rdata
);
    logic scl_rise, scl_fall, start_det, stop_det, sda_s;

    i2c_tgt_cond_det u_cond (
        .clk       (clk),
        .rst_n     (reset),
        .scl_i     (bus.scl_i),
        .sda_i     (bus.sda_i),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det),
        .sda_s     (sda_s)
    );

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]        shift_q, shift_d;
    logic [REG_AW-1:0] ptr_q, ptr_d, ptr_nxt;
    logic              sda_oe_q, sda_oe_d, busy_q, busy_d, wr_valid_q, wr_valid_d;
    logic [REG_AW-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]        wr_data_q, wr_data_d, loc_rdata_q, loc_rdata_d;
    logic [7:0]        regs_q [NUM_REGS];
    logic [7:0]        regs_d [NUM_REGS];
    logic [7:0]        byte_in;
    logic              last_bit;

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        ptr_d      = ptr_q;
        sda_oe_d   = sda_oe_q;
        busy_d     = busy_q;
        wr_valid_d = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        regs_d     = regs_q;
        byte_in    = {shift_q[6:0], sda_s};
        last_bit   = (bit_cnt_q == CNT_W'(BYTE_BITS - 1));
        ptr_nxt    = ptr_q + REG_AW'(1);

        if (start_det) begin
            state_d   = ADDR;
            bit_cnt_d = '0;
            sda_oe_d  = 1'b0;
        end else if (stop_det) begin
            state_d   = IDLE;
            bit_cnt_d = '0;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b0;
        end else begin
            case (state_q)
                ADDR, PTR, WDATA: begin
                    if (scl_rise) begin
                        shift_d   = byte_in;
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        if (last_bit) begin
                            case (state_q)
                                ADDR: begin
                                    if (byte_in[7:1] == DEV_ADDR) begin
                                        state_d = ADDR_ACK;
                                        busy_d  = 1'b1;
                                    end else begin
                                        state_d = WAIT_STOP;
                                        busy_d  = 1'b0;
                                    end
                                end
                                PTR: begin
                                    ptr_d   = byte_in[REG_AW-1:0];
                                    state_d = PTR_ACK;
                                end
                                default: begin
                                    regs_d[ptr_q] = byte_in;
                                    wr_valid_d    = 1'b1;
                                    wr_addr_d     = ptr_q;
                                    wr_data_d     = byte_in;
                                    ptr_d         = ptr_nxt;
                                    state_d       = WACK;
                                end
                            endcase
                        end
                    end
                end
                // bit_cnt 8: ACK not yet driven; 9: ACK clock seen, release on next fall
                ADDR_ACK, PTR_ACK, WACK: begin
                    if (scl_fall && bit_cnt_q == CNT_W'(BYTE_BITS)) begin
                        sda_oe_d = ~I2C_ACK;
                    end else if (scl_rise) begin
                        bit_cnt_d = CNT_W'(BYTE_BITS + 1);
                    end else if (scl_fall && bit_cnt_q == CNT_W'(BYTE_BITS + 1)) begin
                        bit_cnt_d = '0;
                        sda_oe_d  = 1'b0;
                        if (state_q == ADDR_ACK && shift_q[0]) begin
                            state_d  = RDATA;
                            shift_d  = regs_q[ptr_q];
                            sda_oe_d = ~regs_q[ptr_q][7];
                        end else if (state_q == ADDR_ACK) begin
                            state_d = PTR;
                        end else begin
                            state_d = WDATA;
                        end
                    end
                end
                RDATA: begin
                    if (scl_rise) begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end else if (scl_fall && bit_cnt_q != '0) begin
                        if (bit_cnt_q == CNT_W'(BYTE_BITS)) begin
                            sda_oe_d = 1'b0;
                            state_d  = RACK;
                        end else begin
                            shift_d  = {shift_q[6:0], 1'b0};
                            sda_oe_d = ~shift_q[6];
                        end
                    end
                end
                // Pointer advances past every byte read, ACKed or not
                RACK: begin
                    if (scl_rise && bit_cnt_q == CNT_W'(BYTE_BITS)) begin
                        ptr_d = ptr_nxt;
                        if (sda_s == I2C_ACK) begin
                            shift_d   = regs_q[ptr_nxt];
                            bit_cnt_d = CNT_W'(BYTE_BITS + 1);
                        end else begin
                            state_d  = WAIT_STOP;
                            sda_oe_d = 1'b0;
                        end
                    end else if (scl_fall && bit_cnt_q == CNT_W'(BYTE_BITS + 1)) begin
                        state_d   = RDATA;
                        bit_cnt_d = '0;
                        sda_oe_d  = ~shift_q[7];
                    end
                end
                default: ;
            endcase
        end

        loc_rdata_d = (wr_valid_d && wr_addr_d == loc_addr) ? wr_data_d : regs_q[loc_addr];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            ptr_q       <= '0;
            sda_oe_q    <= 1'b0;
            busy_q      <= 1'b0;
            wr_valid_q  <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            loc_rdata_q <= '0;
            regs_q      <= '{default: '0};
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            ptr_q       <= ptr_d;
            sda_oe_q    <= sda_oe_d;
            busy_q      <= busy_d;
            wr_valid_q  <= wr_valid_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            loc_rdata_q <= loc_rdata_d;
            regs_q      <= regs_d;
        end
    end

    assign bus.sda_oe = sda_oe_q;
    assign busy       = busy_q;
    assign wr_valid   = wr_valid_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign loc_rdata  = loc_rdata_q;
endmodule

// File: tb/tb_i2c_target_regs.sv
// Directed bench for i2c_target_regs: bit-banged I2C master over a wired-AND SDA.
module tb_i2c_target_regs;
    localparam int unsigned AW = 4;
    localparam int          Q  = 6;

    logic          clk = 1'b0;
    logic          reset;
    logic          scl_m, sda_m;
    logic [AW-1:0] loc_addr;
    logic          busy, wr_valid;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data, loc_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    logic [11:0] wr_log[$];
    bit          oe_seen, busy_seen;

    i2c_tgt_if bus ();
    assign bus.scl_i = scl_m;
    assign bus.sda_i = sda_m & ~bus.sda_oe;

    i2c_target_regs #(.DEV_ADDR(7'h50), .NUM_REGS(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .busy      (busy),
        .wr_valid  (wr_valid),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .loc_addr  (loc_addr),
        .loc_rdata (loc_rdata)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_valid) wr_log.push_back({wr_addr, wr_data});
        if (bus.sda_oe) oe_seen = 1'b1;
        if (busy) busy_seen = 1'b1;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clock_bit(input logic b, output logic s);
        sda_m = b;
        tick(Q);
        scl_m = 1'b1;
        tick(Q);
        s = bus.sda_i;
        tick(Q);
        scl_m = 1'b0;
        tick(Q);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; tick(Q);
        scl_m = 1'b1; tick(Q);
        sda_m = 1'b0; tick(Q);
        scl_m = 1'b0; tick(Q);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; tick(Q);
        scl_m = 1'b1; tick(Q);
        sda_m = 1'b1; tick(Q);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) clock_bit(b[i], s);
        clock_bit(1'b1, ack);
    endtask

    task automatic read_byte(input logic mack, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            clock_bit(1'b1, s);
            d[i] = s;
        end
        clock_bit(mack, s);
    endtask

    task automatic test_reset();
        reset = 1'b0; scl_m = 1'b1; sda_m = 1'b1; loc_addr = '0;
        tick(4);
        n_checks++;
        if ({bus.sda_oe, busy, wr_valid} !== 3'b000) begin
            n_fail++; $display("FAIL reset_ctrl: got %b expected 000", {bus.sda_oe, busy, wr_valid});
        end
        n_checks++;
        if ({wr_addr, wr_data, loc_rdata} !== 20'h0) begin
            n_fail++; $display("FAIL reset_data: got %h expected 00000", {wr_addr, wr_data, loc_rdata});
        end
        reset = 1'b1;
        tick(4);
    endtask

    task automatic test_write();
        logic [7:0] bytes [4] = '{8'hA0, 8'h03, 8'h5A, 8'hC3};
        logic ack;
        wr_log.delete();
        i2c_start();
        for (int i = 0; i < 4; i++) begin
            write_byte(bytes[i], ack);
            n_checks++;
            if (ack !== 1'b0) begin
                n_fail++; $display("FAIL write_ack%0d: got %b expected 0", i, ack);
            end
        end
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL write_busy: got %b expected 1", busy); end
        i2c_stop();
        tick(2);
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL write_busy_stop: got %b expected 0", busy); end
        n_checks++;
        if (wr_log.size() !== 2) begin
            n_fail++; $display("FAIL write_count: got %0d expected 2", wr_log.size());
        end else begin
            n_checks++;
            if (wr_log[0] !== 12'h35A || wr_log[1] !== 12'h4C3) begin
                n_fail++; $display("FAIL write_events: got %h %h expected 35a 4c3", wr_log[0], wr_log[1]);
            end
        end
        loc_addr = 4'd4;
        tick(1);
        n_checks++;
        if (loc_rdata !== 8'hC3) begin n_fail++; $display("FAIL write_loc4: got %h expected c3", loc_rdata); end
    endtask

    task automatic test_read();
        logic ack0, ack1, ack2;
        logic [7:0] d0, d1, d2;
        i2c_start();
        write_byte(8'hA0, ack0);
        write_byte(8'h03, ack1);
        i2c_start();
        write_byte(8'hA1, ack2);
        n_checks++;
        if ({ack0, ack1, ack2} !== 3'b000) begin
            n_fail++; $display("FAIL read_acks: got %b expected 000", {ack0, ack1, ack2});
        end
        read_byte(1'b0, d0);
        read_byte(1'b1, d1);
        n_checks++;
        if (d0 !== 8'h5A) begin n_fail++; $display("FAIL read_byte0: got %h expected 5a", d0); end
        n_checks++;
        if (d1 !== 8'hC3) begin n_fail++; $display("FAIL read_byte1: got %h expected c3", d1); end
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL read_busy: got %b expected 1", busy); end
        i2c_stop();
        tick(2);
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL read_busy_stop: got %b expected 0", busy); end
        // current-address read continues from ptr=5 (reg5 still 0)
        i2c_start();
        write_byte(8'hA1, ack0);
        read_byte(1'b1, d2);
        i2c_stop();
        n_checks++;
        if (d2 !== 8'h00 || ack0 !== 1'b0) begin
            n_fail++; $display("FAIL read_ptr5: got %h/%b expected 00/0", d2, ack0);
        end
    endtask

    task automatic test_addr_miss();
        logic ack0, ack1;
        wr_log.delete();
        oe_seen = 1'b0; busy_seen = 1'b0;
        i2c_start();
        write_byte(8'hA2, ack0);
        write_byte(8'h11, ack1);
        i2c_stop();
        tick(2);
        n_checks++;
        if ({ack0, ack1} !== 2'b11) begin n_fail++; $display("FAIL miss_nack: got %b expected 11", {ack0, ack1}); end
        n_checks++;
        if (oe_seen !== 1'b0) begin n_fail++; $display("FAIL miss_oe: got %b expected 0", oe_seen); end
        n_checks++;
        if (busy_seen !== 1'b0) begin n_fail++; $display("FAIL miss_busy: got %b expected 0", busy_seen); end
        n_checks++;
        if (wr_log.size() !== 0) begin n_fail++; $display("FAIL miss_wr: got %0d expected 0", wr_log.size()); end
    endtask

    task automatic test_wrap();
        logic a0, a1, a2, a3;
        wr_log.delete();
        i2c_start();
        write_byte(8'hA0, a0);
        write_byte(8'h1F, a1);
        write_byte(8'h11, a2);
        write_byte(8'h22, a3);
        i2c_stop();
        tick(2);
        n_checks++;
        if ({a0, a1, a2, a3} !== 4'b0000) begin
            n_fail++; $display("FAIL wrap_acks: got %b expected 0000", {a0, a1, a2, a3});
        end
        n_checks++;
        if (wr_log.size() !== 2) begin
            n_fail++; $display("FAIL wrap_count: got %0d expected 2", wr_log.size());
        end else begin
            n_checks++;
            if (wr_log[0] !== 12'hF11 || wr_log[1] !== 12'h022) begin
                n_fail++; $display("FAIL wrap_events: got %h %h expected f11 022", wr_log[0], wr_log[1]);
            end
        end
        loc_addr = 4'd15;
        tick(1);
        n_checks++;
        if (loc_rdata !== 8'h11) begin n_fail++; $display("FAIL wrap_reg15: got %h expected 11", loc_rdata); end
        loc_addr = 4'd0;
        tick(1);
        n_checks++;
        if (loc_rdata !== 8'h22) begin n_fail++; $display("FAIL wrap_reg0: got %h expected 22", loc_rdata); end
    endtask

    task automatic test_abort();
        logic a0, a1, s;
        logic [3:0] part = 4'b1010;
        wr_log.delete();
        i2c_start();
        write_byte(8'hA0, a0);
        write_byte(8'h07, a1);
        for (int i = 3; i >= 0; i--) clock_bit(part[i], s);
        i2c_stop();
        tick(2);
        n_checks++;
        if (wr_log.size() !== 0) begin n_fail++; $display("FAIL abort_wr: got %0d expected 0", wr_log.size()); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b expected 0", busy); end
        i2c_start();
        write_byte(8'hA0, a0);
        write_byte(8'h07, a1);
        write_byte(8'h99, s);
        i2c_stop();
        tick(2);
        n_checks++;
        if ({a0, a1, s} !== 3'b000) begin n_fail++; $display("FAIL abort_retry_ack: got %b expected 000", {a0, a1, s}); end
        n_checks++;
        if (wr_log.size() !== 1 || wr_log[0] !== 12'h799) begin
            n_fail++; $display("FAIL abort_retry_wr: got %0d entries first %h expected 1 entry 799", wr_log.size(), (wr_log.size() > 0) ? wr_log[0] : 12'hxxx);
        end
        loc_addr = 4'd7;
        tick(1);
        n_checks++;
        if (loc_rdata !== 8'h99) begin n_fail++; $display("FAIL abort_reg7: got %h expected 99", loc_rdata); end
    endtask

    task automatic test_reset_mid_read();
        logic a0, a1, a2;
        i2c_start();
        write_byte(8'hA0, a0);
        write_byte(8'h03, a1);
        i2c_start();
        write_byte(8'hA1, a2);
        tick(2);
        n_checks++;
        if (bus.sda_oe !== 1'b1) begin n_fail++; $display("FAIL rst_pre_oe: got %b expected 1", bus.sda_oe); end
        reset = 1'b0;
        #1;
        n_checks++;
        if (bus.sda_oe !== 1'b0) begin n_fail++; $display("FAIL rst_async_oe: got %b expected 0", bus.sda_oe); end
        tick(3);
        reset = 1'b1;
        tick(2);
        sda_m = 1'b1;
        scl_m = 1'b1;
        tick(4);
        n_checks++;
        if (busy !== 1'b0 || bus.sda_oe !== 1'b0) begin
            n_fail++; $display("FAIL rst_idle: got busy=%b oe=%b expected 0 0", busy, bus.sda_oe);
        end
        for (int r = 0; r < 16; r++) begin
            loc_addr = AW'(r);
            tick(1);
            n_checks++;
            if (loc_rdata !== 8'h00) begin n_fail++; $display("FAIL rst_reg%0d: got %h expected 00", r, loc_rdata); end
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_addr_miss();
        test_wrap();
        test_abort();
        test_reset_mid_read();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end
endmodule
